// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared types and constants for the sequential nibble-serial ALU
package ula_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [2:0] {
        ULA_ADD    = 3'd0,
        ULA_SUB    = 3'd1,
        ULA_AND    = 3'd2,
        ULA_OR     = 3'd3,
        ULA_XOR    = 3'd4,
        ULA_PASS_A = 3'd5
    } ula_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ula_state_e;

endpackage

// File: rtl/ula_fatia_4b.sv
// rtl/ula_fatia_4b.sv - combinational 4-bit ALU slice with carry in/out and carry into bit 3
module ula_fatia_4b
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout,
    output logic       c3
);

    logic [3:0] bb;
    logic [3:0] lo;
    logic [1:0] hi;

    // Subtraction is a + ~b with the caller seeding cin=1 on the first slice.
    assign bb = (op == ULA_SUB) ? ~b : b;
    assign lo = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b000, cin};
    assign hi = {1'b0, a[3]} + {1'b0, bb[3]} + {1'b0, lo[3]};

    always_comb begin
        f    = 4'h0;
        cout = 1'b0;
        c3   = 1'b0;
        case (op)
            ULA_ADD, ULA_SUB: begin
                f    = {hi[0], lo[2:0]};
                cout = hi[1];
                c3   = lo[3];
            end
            ULA_AND:    f = a & b;
            ULA_OR:     f = a | b;
            ULA_XOR:    f = a ^ b;
            ULA_PASS_A: f = a;
            default:    f = 4'h0;
        endcase
    end

endmodule

// File: rtl/ula_sequencial.sv
// rtl/ula_sequencial.sv - WIDTH-bit ALU iterating one 4-bit slice per cycle; optional ULA_FLAGS_EN adds zero/ovf
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout
`ifdef ULA_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("ula_sequencial: WIDTH must be a multiple of 4 and >= 4");
    end

    ula_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       op_r;
    logic             carry;
    logic [3:0]       s_f;
    logic             s_cout;
    logic             s_c3;
    logic [WIDTH-1:0] f_next;
    logic             last;

    ula_fatia_4b u_fatia (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .op   (op_r),
        .cin  (carry),
        .f    (s_f),
        .cout (s_cout),
`ifdef ULA_FLAGS_EN
        .c3   (s_c3)
`else
        .c3   ()
`endif
    );

`ifndef ULA_FLAGS_EN
    assign s_c3 = 1'b0;
`endif

    // Earlier nibbles live in a shadow register so f only changes when the whole result is ready.
    if (WIDTH > SLICE_W) begin : g_shadow
        logic [WIDTH-SLICE_W-1:0] f_sh;
        assign f_next = {s_f, f_sh};
        always_ff @(posedge clk) begin
            if (rst) begin
                f_sh <= '0;
            end else if (state == CALC) begin
                f_sh <= f_next[WIDTH-1:SLICE_W];
            end
        end
    end else begin : g_noshadow
        assign f_next = s_f;
    end

    assign last      = (cnt == CNT_W'(NSLICE - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            op_r  <= 3'd0;
            carry <= 1'b0;
            f     <= '0;
            cout  <= 1'b0;
`ifdef ULA_FLAGS_EN
            zero  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_r  <= op;
                        carry <= (op == ULA_SUB);
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    carry <= s_cout;
                    if (last) begin
                        f     <= f_next;
                        cout  <= s_cout;
`ifdef ULA_FLAGS_EN
                        zero  <= (f_next == '0);
                        ovf   <= s_c3 ^ s_cout;
`endif
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequencial.sv
// tb/tb_ula_sequencial.sv - directed self-checking bench for ula_sequencial (WIDTH=8 and WIDTH=16); honours ULA_FLAGS_EN
module tb_ula_sequencial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, cout8;
    logic [7:0]  a8 = '0, b8 = '0, f8;
    logic [2:0]  op8 = '0;
    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, cout16;
    logic [15:0] a16 = '0, b16 = '0, f16;
    logic [2:0]  op16 = '0;
`ifdef ULA_FLAGS_EN
    logic        zero8, ovf8, zero16, ovf16;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ula_sequencial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .f(f8), .cout(cout8)
`ifdef ULA_FLAGS_EN
        , .zero(zero8), .ovf(ovf8)
`endif
    );

    ula_sequencial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .f(f16), .cout(cout16)
`ifdef ULA_FLAGS_EN
        , .zero(zero16), .ovf(ovf16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation and waits for out_valid; edges counts the accepting edge as 1.
    task automatic run(input bit w16, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [2:0] iop, input int lat,
                       input logic [15:0] ef, input logic ec, input string tag);
        int edges;
        if (w16) begin
            a16 = ia; b16 = ib; op16 = iop; in_valid16 = 1'b1;
            chk({tag, "_in_ready"}, in_ready16, 1);
        end else begin
            a8 = ia[7:0]; b8 = ib[7:0]; op8 = iop; in_valid8 = 1'b1;
            chk({tag, "_in_ready"}, in_ready8, 1);
        end
        tick();
        in_valid8  = 1'b0;
        in_valid16 = 1'b0;
        edges = 1;
        while (!(w16 ? out_valid16 : out_valid8) && edges < 40) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, edges, lat);
        chk({tag, "_f"}, w16 ? f16 : {8'h00, f8}, ef);
        chk({tag, "_cout"}, w16 ? cout16 : cout8, ec);
    endtask

    task automatic release_result(input bit w16, input string tag);
        if (w16) out_ready16 = 1'b1; else out_ready8 = 1'b1;
        tick();
        out_ready8  = 1'b0;
        out_ready16 = 1'b0;
        chk({tag, "_rel_out_valid"}, w16 ? out_valid16 : out_valid8, 0);
        chk({tag, "_rel_in_ready"}, w16 ? in_ready16 : in_ready8, 1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_f", f8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst16_in_ready", in_ready16, 1);
        chk("rst16_f", f16, 0);
`ifdef ULA_FLAGS_EN
        chk("rst_zero", zero8, 0);
        chk("rst_ovf", ovf8, 0);
`endif

        run(0, 16'h00F0, 16'h001F, 3'd0, 3, 16'h000F, 1'b1, "add_f0_1f");
`ifdef ULA_FLAGS_EN
        chk("add_f0_1f_ovf", ovf8, 0);
`endif
        release_result(0, "add_f0_1f");

        run(0, 16'h0005, 16'h0007, 3'd1, 3, 16'h00FE, 1'b0, "sub_05_07");
`ifdef ULA_FLAGS_EN
        chk("sub_05_07_zero", zero8, 0);
        chk("sub_05_07_ovf", ovf8, 0);
`endif
        release_result(0, "sub_05_07");

        run(0, 16'h0080, 16'h0001, 3'd1, 3, 16'h007F, 1'b1, "sub_80_01");
`ifdef ULA_FLAGS_EN
        chk("sub_80_01_ovf", ovf8, 1);
`endif
        release_result(0, "sub_80_01");

        run(0, 16'h0010, 16'h0010, 3'd1, 3, 16'h0000, 1'b1, "sub_10_10");
`ifdef ULA_FLAGS_EN
        chk("sub_10_10_zero", zero8, 1);
`endif
        release_result(0, "sub_10_10");

        run(0, 16'h00C3, 16'h005A, 3'd2, 3, 16'h0042, 1'b0, "and");
        release_result(0, "and");
        run(0, 16'h00C3, 16'h005A, 3'd3, 3, 16'h00DB, 1'b0, "or");
        release_result(0, "or");
        run(0, 16'h00C3, 16'h005A, 3'd5, 3, 16'h00C3, 1'b0, "pass_a");
        release_result(0, "pass_a");

        // Back-pressure in DONE; a new request presented meanwhile must be ignored.
        run(0, 16'h003C, 16'h0011, 3'd0, 3, 16'h004D, 1'b0, "hold");
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'hFF;
            b8 = 8'hFF;
            tick();
            chk("hold_f", f8, 8'h4D);
            chk("hold_cout", cout8, 0);
            chk("hold_out_valid", out_valid8, 1);
            chk("hold_in_ready", in_ready8, 0);
        end
        in_valid8 = 1'b0;
        release_result(0, "hold");
        tick();
        chk("idle_keeps_f", f8, 8'h4D);

        a8 = 8'h55; b8 = 8'h22; op8 = 3'd0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready8, 1);
        chk("midrst_out_valid", out_valid8, 0);
        chk("midrst_f", f8, 0);
        chk("midrst_cout", cout8, 0);
        run(0, 16'h0001, 16'h0001, 3'd0, 3, 16'h0002, 1'b0, "after_rst");
        release_result(0, "after_rst");

        run(1, 16'hAAAA, 16'hFFFF, 3'd4, 5, 16'h5555, 1'b0, "w16_xor");
        release_result(1, "w16_xor");
        run(1, 16'h1234, 16'h5678, 3'd7, 5, 16'h0000, 1'b0, "w16_rsvd");
        release_result(1, "w16_rsvd");
        run(1, 16'hFFFF, 16'h0001, 3'd0, 5, 16'h0000, 1'b1, "w16_add");
`ifdef ULA_FLAGS_EN
        chk("w16_add_zero", zero16, 1);
        chk("w16_add_ovf", ovf16, 0);
`endif
        release_result(1, "w16_add");
        run(1, 16'h7FFF, 16'h0001, 3'd0, 5, 16'h8000, 1'b0, "w16_add_ovf");
`ifdef ULA_FLAGS_EN
        chk("w16_add_ovf_flag", ovf16, 1);
        chk("w16_add_ovf_zero", zero16, 0);
`endif
        release_result(1, "w16_add_ovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
